// File: rtl/mem_dbus_access_pkg.sv
// Shared types and load/store operation codes for the MEM-stage data-bus access unit.
// Pure declarations; no timing or flow-control behaviour lives here.
package mem_dbus_access_pkg;

  localparam int DBUS_SEL_W = 4;

  typedef logic [7:0]            aluop_t;
  typedef logic [DBUS_SEL_W-1:0] dbus_sel_t;

  localparam aluop_t EXE_LB_OP  = 8'b1110_0000;
  localparam aluop_t EXE_LH_OP  = 8'b1110_0001;
  localparam aluop_t EXE_LW_OP  = 8'b1110_0011;
  localparam aluop_t EXE_LBU_OP = 8'b1110_0100;
  localparam aluop_t EXE_LHU_OP = 8'b1110_0101;
  localparam aluop_t EXE_SB_OP  = 8'b1110_1000;
  localparam aluop_t EXE_SH_OP  = 8'b1110_1001;
  localparam aluop_t EXE_SW_OP  = 8'b1110_1011;

endpackage

// File: rtl/mem_dbus_access_if.sv
// Data-bus request/ack bundle between the MEM-stage access unit (master) and memory (slave).
// Request is held until ack; rdata is valid in the ack cycle.
interface mem_dbus_access_if;
  import mem_dbus_access_pkg::*;

  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  dbus_sel_t   dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_ack, dbus_rdata
  );

endinterface

// File: rtl/mem_lsu_fmt.sv
// Combinational lane select, store replication and load extract/extend keyed on aluop and byte offset.
// Zero latency, no flow control.
module mem_lsu_fmt
  import mem_dbus_access_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [1:0]  offset,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        misaligned,
  output dbus_sel_t   sel,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  dbus_sel_t   byte_sel;
  dbus_sel_t   half_sel;

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    rbyte    = 8'h00;
    byte_sel = 4'b0000;
    case (offset)
      2'd0: begin rbyte = rdata[31:24]; byte_sel = 4'b1000; end
      2'd1: begin rbyte = rdata[23:16]; byte_sel = 4'b0100; end
      2'd2: begin rbyte = rdata[15:8];  byte_sel = 4'b0010; end
      default: begin rbyte = rdata[7:0]; byte_sel = 4'b0001; end
    endcase
    rhalf    = offset[1] ? rdata[15:0] : rdata[31:16];
    half_sel = offset[1] ? 4'b0011 : 4'b1100;
  end

  always_comb begin
    is_mem     = 1'b0;
    is_load    = 1'b0;
    misaligned = 1'b0;
    sel        = 4'b0000;
    wdata      = 32'h0;
    ldata      = 32'h0;
    case (aluop)
      EXE_LB_OP: begin
        is_mem = 1'b1; is_load = 1'b1; sel = byte_sel;
        ldata  = {{24{rbyte[7]}}, rbyte};
      end
      EXE_LBU_OP: begin
        is_mem = 1'b1; is_load = 1'b1; sel = byte_sel;
        ldata  = {24'h0, rbyte};
      end
      EXE_LH_OP: begin
        is_mem = 1'b1; is_load = 1'b1; sel = half_sel;
        misaligned = offset[0];
        ldata  = {{16{rhalf[15]}}, rhalf};
      end
      EXE_LHU_OP: begin
        is_mem = 1'b1; is_load = 1'b1; sel = half_sel;
        misaligned = offset[0];
        ldata  = {16'h0, rhalf};
      end
      EXE_LW_OP: begin
        is_mem = 1'b1; is_load = 1'b1; sel = 4'b1111;
        misaligned = |offset;
        ldata  = rdata;
      end
      EXE_SB_OP: begin
        is_mem = 1'b1; sel = byte_sel;
        wdata  = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        is_mem = 1'b1; sel = half_sel;
        misaligned = offset[0];
        wdata  = {2{reg2[15:0]}};
      end
      EXE_SW_OP: begin
        is_mem = 1'b1; sel = 4'b1111;
        misaligned = |offset;
        wdata  = reg2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_dbus_access.sv
// MEM-stage load/store unit: runs one data-bus transaction per memory op and formats write-back.
// Best case 3 cycles per memory op (+1 per extra wait cycle); stallreq holds the pipeline meanwhile.
module mem_dbus_access
  import mem_dbus_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [4:0]         mem_wd,
  input  logic               mem_wreg,
  input  logic [31:0]        mem_wdata,
  input  aluop_t             mem_aluop,
  input  logic [31:0]        mem_mem_addr,
  input  logic [31:0]        mem_reg2,
  output logic [4:0]         wb_wd,
  output logic               wb_wreg,
  output logic [31:0]        wb_wdata,
  mem_dbus_access_if.master  dbus,
  output logic               stallreq,
  output logic               addr_err,
  output logic               bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  dbus_sel_t        sel_q, sel_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic        is_mem;
  logic        is_load;
  logic        misaligned;
  dbus_sel_t   fmt_sel;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_ldata;

  mem_lsu_fmt u_fmt (
    .aluop      (mem_aluop),
    .offset     (mem_mem_addr[1:0]),
    .reg2       (mem_reg2),
    .rdata      (dbus.dbus_rdata),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .misaligned (misaligned),
    .sel        (fmt_sel),
    .wdata      (fmt_wdata),
    .ldata      (fmt_ldata)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= '0;
      wdata_q <= 32'h0;
      cap_q   <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    stallreq = 1'b0;
    addr_err = 1'b0;
    bus_err  = 1'b0;
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          wb_wreg = 1'b0;
          if (misaligned) begin
            addr_err = 1'b1;
          end else begin
            stallreq = 1'b1;
            req_d    = 1'b1;
            we_d     = ~is_load;
            addr_d   = {mem_mem_addr[31:2], 2'b00};
            sel_d    = fmt_sel;
            wdata_d  = fmt_wdata;
            cap_d    = 32'h0;
            cnt_d    = '0;
            err_d    = 1'b0;
            state_d  = S_REQ;
          end
        end
      end

      S_REQ: begin
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
        if (dbus.dbus_ack) begin
          req_d   = 1'b0;
          cap_d   = fmt_ldata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // EX/MEM is still frozen here, so mem_aluop/mem_wreg describe the finished op.
        wb_wdata = cap_q;
        wb_wreg  = is_load & ~err_q & mem_wreg;
        bus_err  = err_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_sel   = sel_q;
  assign dbus.dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_dbus_access.sv
// Bench for mem_dbus_access: scripted bus slave, reference model and scoreboard queue.
module tb_mem_dbus_access;
  import mem_dbus_access_pkg::*;

  localparam aluop_t OP_NOP  = 8'h00;
  localparam aluop_t OP_ADDU = 8'h21;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    int          stall;
    logic        berr;
    logic        aerr;
    bit          chk_wdata;
    bit          chk_bus;
    bit          chk_bwd;
  } rec_t;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  aluop_t      mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        addr_err;
  logic        bus_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t sb_q[$];

  mem_dbus_access_if dbus();

  mem_dbus_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .dbus         (dbus),
    .stallreq     (stallreq),
    .addr_err     (addr_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pass_data(input logic [31:0] addr);
    return 32'h5A5A_0000 ^ addr;
  endfunction

  // Reference behaviour written from the access rules, independent of the RTL structure.
  function automatic rec_t model(input aluop_t op, input logic [31:0] addr, input logic [31:0] reg2,
                                 input logic [31:0] rdata, input logic wreg, input int ack_at);
    rec_t r;
    int o, sz, s;
    logic ld, st, mis;
    logic [31:0] sh;
    r  = '{default: 0};
    o  = int'(addr[1:0]);
    ld = op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    st = op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    sz = (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) ? 1 :
         (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? 2 : 4;
    mis = (ld || st) && ((o % sz) != 0);
    if (!(ld || st) || mis) begin
      r.wdata = pass_data(addr); r.wreg = mis ? 1'b0 : wreg;
      r.chk_wdata = 1; r.aerr = mis;
      return r;
    end
    r.berr  = (ack_at < 0) || (ack_at > 15);
    r.stall = r.berr ? 17 : 2 + ack_at;
    r.chk_bus = 1; r.we = st; r.baddr = addr & ~32'h3;
    s = ((1 << sz) - 1) << (4 - sz - o);
    r.sel = s[3:0];
    if (st) begin
      r.chk_bwd = 1;
      r.bwdata = (sz == 1) ? {4{reg2[7:0]}} : (sz == 2) ? {2{reg2[15:0]}} : reg2;
    end
    if (ld && !r.berr) begin
      sh = rdata >> (8 * (4 - sz - o));
      r.chk_wdata = 1; r.wreg = wreg;
      case (sz)
        1: r.wdata = (op == EXE_LBU_OP) ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        2: r.wdata = (op == EXE_LHU_OP) ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        default: r.wdata = rdata;
      endcase
    end
    return r;
  endfunction

  // Presents one EX/MEM op, plays the memory side, and records what the DUT did.
  task automatic bus_cycle(input aluop_t op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input logic wreg, input int ack_at, output rec_t obs);
    int  req_n;
    bit  done;
    obs   = '{default: 0};
    req_n = 0;
    done  = 0;
    @(negedge clk);
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
    mem_wd = addr[6:2]; mem_wreg = wreg; mem_wdata = pass_data(addr);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      dbus.dbus_ack = 1'b0;
      if (addr_err) obs.aerr = 1'b1;
      if (!stallreq) begin
        obs.wdata = wb_wdata; obs.wreg = wb_wreg; obs.berr = bus_err;
        done = 1;
        break;
      end
      obs.stall++;
      if (dbus.dbus_req) begin
        obs.we = dbus.dbus_we; obs.sel = dbus.dbus_sel;
        obs.baddr = dbus.dbus_addr; obs.bwdata = dbus.dbus_wdata;
        if (req_n == ack_at) begin
          dbus.dbus_ack = 1'b1; dbus.dbus_rdata = rdata;
        end
        req_n++;
      end
    end
    if (!done) obs.stall = -1;
    mem_aluop = OP_NOP; mem_wreg = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; mem_aluop = OP_NOP; mem_wreg = 1'b0; mem_wd = 5'd0;
    mem_wdata = 32'h0; mem_mem_addr = 32'h0; mem_reg2 = 32'h0;
    dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({dbus.dbus_req, dbus.dbus_we, dbus.dbus_sel} !== 6'b0) begin
      n_bad++; $display("FAIL reset_bus_ctl got req/we/sel=%b want 0", {dbus.dbus_req, dbus.dbus_we, dbus.dbus_sel});
    end
    n_cmp++;
    if ({dbus.dbus_addr, dbus.dbus_wdata} !== 64'h0) begin
      n_bad++; $display("FAIL reset_bus_data got addr=%h wdata=%h want 0", dbus.dbus_addr, dbus.dbus_wdata);
    end
    n_cmp++;
    if ({stallreq, addr_err, bus_err, wb_wreg} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {stallreq, addr_err, bus_err, wb_wreg});
    end
    clr_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({dbus.dbus_req, stallreq} !== 2'b00) begin
      n_bad++; $display("FAIL reset_stray_ack got req/stall=%b want 00", {dbus.dbus_req, stallreq});
    end
    dbus.dbus_ack = 1'b0;
  endtask

  task automatic test_loads();
    aluop_t      ops[6]  = '{EXE_LW_OP, EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LB_OP};
    logic [31:0] adr[6]  = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h404};
    logic [31:0] rd[6]   = '{32'hDEADBEEF, 32'h0000_00F0, 32'h0000_00F0, 32'h0000_8001, 32'h0000_8001, 32'h80FF_FFFF};
    int          acks[6] = '{0, 0, 1, 0, 2, 0};
    rec_t e, o;
    for (int i = 0; i < 14; i++) begin
      aluop_t op; logic [31:0] a, d; int k;
      if (i < 6) begin
        op = ops[i]; a = adr[i]; d = rd[i]; k = acks[i];
      end else begin
        case ($urandom_range(4, 0))
          0: op = EXE_LB_OP; 1: op = EXE_LBU_OP; 2: op = EXE_LH_OP; 3: op = EXE_LHU_OP;
          default: op = EXE_LW_OP;
        endcase
        a = $urandom & 32'hFFFF_FFFC;
        a[1:0] = (op == EXE_LW_OP) ? 2'd0 : (op inside {EXE_LH_OP, EXE_LHU_OP}) ? 2'($urandom_range(1, 0) * 2) : 2'($urandom_range(3, 0));
        d = $urandom; k = $urandom_range(3, 0);
      end
      sb_q.push_back(model(op, a, 32'h0, d, 1'b1, k));
      bus_cycle(op, a, 32'h0, d, 1'b1, k, o);
      e = sb_q.pop_front();
      n_cmp++;
      if (o.stall !== e.stall) begin n_bad++; $display("FAIL load[%0d] stall got %0d want %0d", i, o.stall, e.stall); end
      n_cmp++;
      if (o.wreg !== e.wreg) begin n_bad++; $display("FAIL load[%0d] wb_wreg got %b want %b", i, o.wreg, e.wreg); end
      n_cmp++;
      if (o.wdata !== e.wdata) begin n_bad++; $display("FAIL load[%0d] wb_wdata got %h want %h", i, o.wdata, e.wdata); end
      n_cmp++;
      if ({o.we, o.sel, o.baddr} !== {e.we, e.sel, e.baddr}) begin
        n_bad++; $display("FAIL load[%0d] bus got we=%b sel=%b addr=%h want we=%b sel=%b addr=%h",
                          i, o.we, o.sel, o.baddr, e.we, e.sel, e.baddr);
      end
    end
  endtask

  task automatic test_stores();
    aluop_t      ops[4] = '{EXE_SB_OP, EXE_SH_OP, EXE_SH_OP, EXE_SW_OP};
    logic [31:0] adr[4] = '{32'h201, 32'h300, 32'h302, 32'h40C};
    rec_t e, o;
    for (int i = 0; i < 10; i++) begin
      aluop_t op; logic [31:0] a, r;
      if (i < 4) begin
        op = ops[i]; a = adr[i]; r = 32'h1234_56AB;
      end else begin
        op = ops[$urandom_range(3, 0)];
        a = $urandom & 32'hFFFF_FFFC;
        if (op == EXE_SB_OP) a[1:0] = 2'($urandom_range(3, 0));
        if (op == EXE_SH_OP) a[1] = 1'($urandom_range(1, 0));
        r = $urandom;
      end
      sb_q.push_back(model(op, a, r, 32'h0, 1'b1, i % 3));
      bus_cycle(op, a, r, 32'hCAFE_F00D, 1'b1, i % 3, o);
      e = sb_q.pop_front();
      n_cmp++;
      if (o.stall !== e.stall) begin n_bad++; $display("FAIL store[%0d] stall got %0d want %0d", i, o.stall, e.stall); end
      n_cmp++;
      if (o.wreg !== e.wreg) begin n_bad++; $display("FAIL store[%0d] wb_wreg got %b want %b", i, o.wreg, e.wreg); end
      n_cmp++;
      if ({o.we, o.sel, o.baddr, o.bwdata} !== {e.we, e.sel, e.baddr, e.bwdata}) begin
        n_bad++; $display("FAIL store[%0d] bus got we=%b sel=%b addr=%h wd=%h want we=%b sel=%b addr=%h wd=%h",
                          i, o.we, o.sel, o.baddr, o.bwdata, e.we, e.sel, e.baddr, e.bwdata);
      end
    end
  endtask

  task automatic test_misaligned();
    aluop_t      ops[5] = '{EXE_SW_OP, EXE_LW_OP, EXE_LH_OP, EXE_SH_OP, EXE_LHU_OP};
    logic [31:0] adr[5] = '{32'h102, 32'h101, 32'h103, 32'h201, 32'h305};
    rec_t e, o;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(model(ops[i], adr[i], 32'h0, 32'h0, 1'b1, 0));
      bus_cycle(ops[i], adr[i], 32'h0, 32'h0, 1'b1, 0, o);
      e = sb_q.pop_front();
      n_cmp++;
      if ({o.stall, o.aerr, o.berr, o.wreg} !== {e.stall, e.aerr, e.berr, e.wreg}) begin
        n_bad++; $display("FAIL misalign[%0d] stall/aerr/berr/wreg got %0d/%b/%b/%b want %0d/%b/%b/%b",
                          i, o.stall, o.aerr, o.berr, o.wreg, e.stall, e.aerr, e.berr, e.wreg);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({dbus.dbus_req, addr_err} !== 2'b00) begin
        n_bad++; $display("FAIL misalign[%0d] after got req/aerr=%b want 00", i, {dbus.dbus_req, addr_err});
      end
    end
  endtask

  task automatic test_timeout();
    rec_t e, o;
    sb_q.push_back(model(EXE_LW_OP, 32'h500, 32'h0, 32'h0, 1'b1, -1));
    bus_cycle(EXE_LW_OP, 32'h500, 32'h0, 32'h0, 1'b1, -1, o);
    e = sb_q.pop_front();
    n_cmp++;
    if (o.stall !== e.stall) begin n_bad++; $display("FAIL timeout stall got %0d want %0d", o.stall, e.stall); end
    n_cmp++;
    if ({o.berr, o.wreg} !== {e.berr, e.wreg}) begin
      n_bad++; $display("FAIL timeout berr/wreg got %b%b want %b%b", o.berr, o.wreg, e.berr, e.wreg);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus_err, dbus.dbus_req} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_pulse got berr/req=%b want 00", {bus_err, dbus.dbus_req});
    end
  endtask

  task automatic test_reset_in_req();
    rec_t e, o;
    @(negedge clk);
    mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h300; mem_wreg = 1'b1; mem_wd = 5'd7;
    #1;
    for (int i = 0; i < 5 && !dbus.dbus_req; i++) begin @(negedge clk); #1; end
    n_cmp++;
    if (dbus.dbus_req !== 1'b1) begin n_bad++; $display("FAIL rst_req_enter got req=%b want 1", dbus.dbus_req); end
    clr_n = 1'b0; mem_aluop = OP_NOP; mem_wreg = 1'b0;
    @(negedge clk); #1;
    clr_n = 1'b1; dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'h1111_2222;
    n_cmp++;
    if ({dbus.dbus_req, stallreq, dbus.dbus_addr} !== 34'h0) begin
      n_bad++; $display("FAIL rst_req_cleared got req=%b stall=%b addr=%h want 0", dbus.dbus_req, stallreq, dbus.dbus_addr);
    end
    @(negedge clk); #1;
    dbus.dbus_ack = 1'b0;
    n_cmp++;
    if ({dbus.dbus_req, stallreq, wb_wreg, bus_err} !== 4'b0) begin
      n_bad++; $display("FAIL rst_late_ack got req/stall/wreg/berr=%b want 0000", {dbus.dbus_req, stallreq, wb_wreg, bus_err});
    end
    sb_q.push_back(model(EXE_LW_OP, 32'h304, 32'h0, 32'h7777_8888, 1'b1, 0));
    bus_cycle(EXE_LW_OP, 32'h304, 32'h0, 32'h7777_8888, 1'b1, 0, o);
    e = sb_q.pop_front();
    n_cmp++;
    if ({o.stall, o.wdata} !== {e.stall, e.wdata}) begin
      n_bad++; $display("FAIL rst_recover got stall=%0d data=%h want stall=%0d data=%h", o.stall, o.wdata, e.stall, e.wdata);
    end
  endtask

  task automatic test_back_to_back();
    aluop_t pool[10] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, OP_ADDU, 8'h25};
    rec_t e, o;
    for (int i = 0; i < 24; i++) begin
      aluop_t op; logic [31:0] a, r, d; logic w; int k;
      op = pool[$urandom_range(9, 0)];
      a = $urandom; r = $urandom; d = $urandom; w = 1'($urandom_range(1, 0)); k = $urandom_range(3, 0);
      sb_q.push_back(model(op, a, r, d, w, k));
      bus_cycle(op, a, r, d, w, k, o);
      e = sb_q.pop_front();
      n_cmp++;
      if ({o.stall, o.aerr, o.berr, o.wreg} !== {e.stall, e.aerr, e.berr, e.wreg}) begin
        n_bad++; $display("FAIL b2b[%0d] op=%h stall/aerr/berr/wreg got %0d/%b/%b/%b want %0d/%b/%b/%b",
                          i, op, o.stall, o.aerr, o.berr, o.wreg, e.stall, e.aerr, e.berr, e.wreg);
      end
      if (e.chk_wdata) begin
        n_cmp++;
        if (o.wdata !== e.wdata) begin n_bad++; $display("FAIL b2b[%0d] op=%h wb_wdata got %h want %h", i, op, o.wdata, e.wdata); end
      end
      if (e.chk_bus) begin
        n_cmp++;
        if ({o.we, o.sel, o.baddr} !== {e.we, e.sel, e.baddr}) begin
          n_bad++; $display("FAIL b2b[%0d] op=%h bus got we=%b sel=%b addr=%h want we=%b sel=%b addr=%h",
                            i, op, o.we, o.sel, o.baddr, e.we, e.sel, e.baddr);
        end
      end
      if (e.chk_bwd) begin
        n_cmp++;
        if (o.bwdata !== e.bwdata) begin n_bad++; $display("FAIL b2b[%0d] op=%h dbus_wdata got %h want %h", i, op, o.bwdata, e.bwdata); end
      end
    end
  endtask

  initial begin
    dbus.dbus_ack   = 1'b0;
    dbus.dbus_rdata = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
